// File: rtl/i2s_eth_framer.sv
// i2s_eth_framer: wraps 8-bit AXI-Stream audio frames into Ethernet II frames
// (header + sequence number + payload, zero-padded to the minimum, no FCS).
// Oversized input frames are cut at MAX_PAYLOAD and the rest is discarded.
module i2s_eth_framer #(
   parameter logic [39:0] MAC_PREFIX  = 40'h02_00_00_00_00,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int          MIN_PAYLOAD = 46,
   parameter int          MAX_PAYLOAD = 1500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [3:0]  fpga_index,
   input  logic [3:0]  dst_fpga_index,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic [15:0] frame_count,
   output logic        overflow
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, DROP} state_t;

   // Payload count includes the two sequence-number bytes.
   localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
   localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);

   state_t      state, state_nxt;
   logic [3:0]  byte_idx, byte_idx_nxt;
   logic [10:0] pay_cnt, pay_cnt_nxt;
   logic [10:0] pay_cnt_inc;
   logic [3:0]  src_idx, dst_idx;
   logic [15:0] seq;
   logic [7:0]  hdr_byte;
   logic        start;
   logic        frame_done;

   assign pay_cnt_inc = pay_cnt + 11'd1;
   assign frame_done  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Header byte selected by byte_idx; only advances on a handshake, so it
   // stays stable while the MAC stalls.
   always_comb begin
      hdr_byte = 8'h00;
      case (byte_idx)
         4'd0, 4'd6:  hdr_byte = MAC_PREFIX[39:32];
         4'd1, 4'd7:  hdr_byte = MAC_PREFIX[31:24];
         4'd2, 4'd8:  hdr_byte = MAC_PREFIX[23:16];
         4'd3, 4'd9:  hdr_byte = MAC_PREFIX[15:8];
         4'd4, 4'd10: hdr_byte = MAC_PREFIX[7:0];
         4'd5:        hdr_byte = {4'h0, dst_idx};
         4'd11:       hdr_byte = {4'h0, src_idx};
         4'd12:       hdr_byte = ETHERTYPE[15:8];
         4'd13:       hdr_byte = ETHERTYPE[7:0];
         4'd14:       hdr_byte = seq[15:8];
         4'd15:       hdr_byte = seq[7:0];
      endcase
   end

   // Next-state logic and stream outputs for the framing FSM.
   always_comb begin
      state_nxt     = state;
      byte_idx_nxt  = byte_idx;
      pay_cnt_nxt   = pay_cnt;
      start         = 1'b0;
      overflow      = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && s_axis_tvalid) begin
               start        = 1'b1;
               byte_idx_nxt = 4'd0;
               pay_cnt_nxt  = 11'd0;
               state_nxt    = HEADER;
            end
         end
         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hdr_byte;
            if (m_axis_tready) begin
               byte_idx_nxt = byte_idx + 4'd1;
               if (byte_idx == 4'd15) begin
                  pay_cnt_nxt = 11'd2;
                  state_nxt   = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            if (s_axis_tlast) begin
               m_axis_tlast = (pay_cnt_inc >= MIN_CNT);
            end else if (pay_cnt_inc == MAX_CNT) begin
               m_axis_tlast = 1'b1;
            end
            if (s_axis_tvalid && m_axis_tready) begin
               pay_cnt_nxt = pay_cnt_inc;
               if (s_axis_tlast) begin
                  state_nxt = (pay_cnt_inc >= MIN_CNT) ? IDLE : PAD;
               end else if (pay_cnt_inc == MAX_CNT) begin
                  overflow  = 1'b1;
                  state_nxt = DROP;
               end
            end
         end
         PAD: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = (pay_cnt_inc == MIN_CNT);
            if (m_axis_tready) begin
               pay_cnt_nxt = pay_cnt_inc;
               if (pay_cnt_inc == MIN_CNT) state_nxt = IDLE;
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state, sequence number and completed-frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         byte_idx    <= 4'd0;
         pay_cnt     <= 11'd0;
         seq         <= 16'd0;
         frame_count <= 16'd0;
      end else begin
         state    <= state_nxt;
         byte_idx <= byte_idx_nxt;
         pay_cnt  <= pay_cnt_nxt;
         if (frame_done) begin
            seq         <= seq + 16'd1;
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   // Addresses are captured once per frame so index changes mid-frame are ignored.
   always_ff @(posedge clk) begin
      if (start) begin
         src_idx <= fpga_index;
         dst_idx <= dst_fpga_index;
      end
   end

endmodule

// File: tb/tb_i2s_eth_framer.sv
// Bench for i2s_eth_framer: table of directed frames, randomized backpressure
// frames, overflow on a small-MAX_PAYLOAD instance, reset and enable corners.
module tb_i2s_eth_framer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  fpga_index = 4'd0, dst_fpga_index = 4'd0;
   logic [7:0]  s_tdata = 8'h00;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0;
   logic        m_tready;
   logic        sel = 1'b0;
   logic        bp_en = 1'b0;

   logic        s_rdy_a, mv_a, ml_a, ovf_a;
   logic        s_rdy_b, mv_b, ml_b, ovf_b;
   logic [7:0]  md_a, md_b;
   logic [15:0] fc_a, fc_b;

   logic        s_rdy, mv, ml;
   logic [7:0]  md;
   logic [15:0] fc;

   int checks = 0, errors = 0;
   int cyc = 0;
   int start_cyc = 0, first_cyc = 0, last_cyc = 0;
   int frames_seen = 0;
   int ovf_cnt_a = 0, ovf_cnt_b = 0;
   int stall_chk = 0, stall_err = 0;
   logic       prev_stall = 1'b0, pl = 1'b0;
   logic [7:0] pd = 8'h00;
   logic [8:0] out_q[$];
   logic [8:0] exp_q[$];
   logic [15:0] exp_seq[2];
   logic [15:0] exp_fc[2];

   i2s_eth_framer dut_a (
      .clk(clk), .rst(rst), .enable(enable),
      .fpga_index(fpga_index), .dst_fpga_index(dst_fpga_index),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_rdy_a),
      .m_axis_tdata(md_a), .m_axis_tvalid(mv_a), .m_axis_tlast(ml_a), .m_axis_tready(m_tready),
      .frame_count(fc_a), .overflow(ovf_a)
   );

   i2s_eth_framer #(.MAX_PAYLOAD(64)) dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .fpga_index(fpga_index), .dst_fpga_index(dst_fpga_index),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & sel), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_rdy_b),
      .m_axis_tdata(md_b), .m_axis_tvalid(mv_b), .m_axis_tlast(ml_b), .m_axis_tready(m_tready),
      .frame_count(fc_b), .overflow(ovf_b)
   );

   assign s_rdy = sel ? s_rdy_b : s_rdy_a;
   assign mv    = sel ? mv_b : mv_a;
   assign ml    = sel ? ml_b : ml_a;
   assign md    = sel ? md_b : md_a;
   assign fc    = sel ? fc_b : fc_a;

   initial forever #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // MAC-side ready: random when backpressure is on, otherwise always ready
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: captures accepted bytes, checks stall stability
   always @(negedge clk) begin
      if (rst) begin
         out_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            stall_chk++;
            if (!mv || md != pd || ml != pl) stall_err++;
         end
         prev_stall = mv && !m_tready;
         pd = md;
         pl = ml;
         if (mv && m_tready) begin
            if (out_q.size() == 0) first_cyc = cyc;
            out_q.push_back({ml, md});
            if (ml) begin
               last_cyc = cyc;
               frames_seen++;
            end
         end
         if (ovf_a) ovf_cnt_a++;
         if (ovf_b) ovf_cnt_b++;
      end
   end

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
      end
   endtask

   // Reference: header, seq, payload truncated to maxp-2, zero pad to 60 bytes
   function automatic void build_exp(input int src, input int dst, input logic [15:0] sq,
                                     input logic [7:0] d[$], input int maxp);
      logic [7:0] pfx[5];
      int n;
      pfx = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, pfx[i]});
      exp_q.push_back({1'b0, 8'(dst)});
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, pfx[i]});
      exp_q.push_back({1'b0, 8'(src)});
      exp_q.push_back(9'h088);
      exp_q.push_back(9'h0B5);
      exp_q.push_back({1'b0, sq[15:8]});
      exp_q.push_back({1'b0, sq[7:0]});
      n = d.size();
      if (n > maxp - 2) n = maxp - 2;
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, d[i]});
      while (exp_q.size() < 14 + 46) exp_q.push_back(9'h000);
      exp_q[exp_q.size() - 1][8] = 1'b1;
   endfunction

   task automatic send_frame(input logic [7:0] d[$]);
      int t;
      start_cyc = cyc;
      for (int i = 0; i < d.size(); i++) begin
         s_tdata  = d[i];
         s_tlast  = (i == d.size() - 1);
         s_tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (s_rdy) break;
            t++;
            if (t > 4000) begin
               chk("input handshake timeout", 0, 1);
               s_tvalid = 1'b0;
               s_tlast  = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic run_frame(input string nm, input int src, input int dst,
                            input logic [7:0] d[$], input int maxp);
      int fs0, t, nbad, firstbad;
      fpga_index     = 4'(src);
      dst_fpga_index = 4'(dst);
      out_q.delete();
      fs0 = frames_seen;
      build_exp(src, dst, exp_seq[sel], d, maxp);
      send_frame(d);
      t = 0;
      while (frames_seen == fs0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, " frame completed"}, int'(frames_seen != fs0), 1);
      @(negedge clk);
      exp_seq[sel] = exp_seq[sel] + 16'd1;
      exp_fc[sel]  = exp_fc[sel] + 16'd1;
      chk({nm, " length"}, out_q.size(), exp_q.size());
      nbad = 0;
      firstbad = -1;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) begin
            nbad++;
            if (firstbad < 0) firstbad = i;
         end
      if (nbad != 0)
         $display("FAIL %s first bad byte %0d: got %03h expected %03h", nm, firstbad,
                  out_q[firstbad], exp_q[firstbad]);
      chk({nm, " bad bytes"}, nbad, 0);
      chk({nm, " frame_count"}, int'(fc), int'(exp_fc[sel]));
      if (!bp_en) begin
         chk({nm, " first byte latency"}, first_cyc - start_cyc, 1);
         chk({nm, " frame cycles"}, last_cyc - start_cyc, out_q.size());
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      int src;
      int dst;
      int len;
      int exp_len;
   } vec_t;

   initial begin
      vec_t tbl[6];
      logic [7:0] d[$];
      logic [7:0] sf[20];
      int nbad;

      tbl[0] = '{2, 5, 4, 60};
      tbl[1] = '{1, 3, 100, 116};
      tbl[2] = '{0, 15, 44, 60};
      tbl[3] = '{7, 7, 43, 60};
      tbl[4] = '{3, 9, 45, 61};
      tbl[5] = '{15, 0, 1, 60};
      sf = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h02, 8'h88, 8'hB5, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      exp_seq = '{16'd0, 16'd0};
      exp_fc  = '{16'd0, 16'd0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset m_tvalid", int'(mv), 0);
      chk("reset m_tlast", int'(ml), 0);
      chk("reset m_tdata", int'(md), 0);
      chk("reset s_tready", int'(s_rdy), 0);
      chk("reset frame_count", int'(fc), 0);
      chk("reset overflow", int'(ovf_a), 0);
      @(posedge clk); #1;
      enable = 1'b1;

      // directed table, MAC always ready
      for (int v = 0; v < 6; v++) begin
         d.delete();
         for (int i = 0; i < tbl[v].len; i++) d.push_back(8'(8'hAA + 8'h11 * i));
         run_frame($sformatf("table%0d", v), tbl[v].src, tbl[v].dst, d, 1500);
         chk($sformatf("table%0d expected length", v), out_q.size(), tbl[v].exp_len);
         if (v == 0) begin
            nbad = 0;
            for (int i = 0; i < 20; i++) if (out_q[i][7:0] !== sf[i]) nbad++;
            chk("short frame literal bytes", nbad, 0);
         end
      end

      // random frames under 50% backpressure
      bp_en = 1'b1;
      stall_chk = 0;
      stall_err = 0;
      for (int f = 0; f < 20; f++) begin
         d.delete();
         for (int i = 0; i < int'($urandom_range(1, 200)); i++) d.push_back(8'($urandom));
         run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), d, 1500);
      end
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("stalled output changed", stall_err, 0);
      chk("stalls observed", int'(stall_chk > 0), 1);

      // overflow on the MAX_PAYLOAD=64 instance
      sel = 1'b1;
      d.delete();
      for (int i = 0; i < 100; i++) d.push_back(8'(i + 1));
      run_frame("overflow", 4, 6, d, 64);
      chk("overflow pulses", ovf_cnt_b, 1);
      chk("overflow tlast byte", int'(out_q[77]), int'({1'b1, 8'd62}));
      d.delete();
      for (int i = 0; i < 10; i++) d.push_back(8'(8'h30 + i));
      run_frame("after overflow", 1, 2, d, 64);
      chk("overflow pulses after next frame", ovf_cnt_b, 1);
      sel = 1'b0;

      // reset while presenting header byte 7
      out_q.delete();
      s_tdata  = 8'h11;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      for (int t = 0; t < 100 && out_q.size() < 7; t++) begin
         @(posedge clk); #1;
      end
      chk("bytes before mid-frame reset", out_q.size(), 7);
      rst = 1'b1;
      s_tvalid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid-frame reset m_tvalid", int'(mv), 0);
      chk("mid-frame reset frame_count", int'(fc), 0);
      exp_seq = '{16'd0, 16'd0};
      exp_fc  = '{16'd0, 16'd0};
      @(posedge clk); #1;

      // enable gating, then frame after reset must carry seq 0
      enable = 1'b0;
      d.delete();
      for (int i = 0; i < 50; i++) d.push_back(8'(8'h80 ^ i));
      s_tdata  = d[0];
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      nbad = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (s_rdy || mv) nbad++;
      end
      chk("enable low activity", nbad, 0);
      chk("enable low output bytes", out_q.size(), 0);
      @(posedge clk); #1;
      enable = 1'b1;
      run_frame("after enable", 9, 10, d, 1500);
      chk("seq after reset", int'({out_q[14][7:0], out_q[15][7:0]}), 0);
      chk("no overflow on default instance", ovf_cnt_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
